// File: rtl/test_monitor_pkg.sv
// Shared command codes, register offsets and state encodings for the test monitor.
package test_monitor_pkg;

  localparam logic [31:0] CMD_CHECK_EQ       = 32'h0000_0000;
  localparam logic [31:0] CMD_CHECK_ALL_FAIL = 32'h0000_0001;
  localparam logic [31:0] DONE_CODE          = 32'h0D15_EA5E;
  localparam logic [31:0] FAIL_CODE          = 32'hDEAD_BEEF;

  // Offsets inside a 64-byte channel window
  localparam logic [5:0] OFF_CMD      = 6'h00;
  localparam logic [5:0] OFF_ARG_A    = 6'h04;
  localparam logic [5:0] OFF_ARG_B    = 6'h08;
  localparam logic [5:0] OFF_CALLER   = 6'h0C;
  localparam logic [5:0] OFF_CH_STATE = 6'h10;

  // Offsets inside the global block
  localparam logic [5:0] G_STATUS      = 6'h00;
  localparam logic [5:0] G_FAIL_COUNT  = 6'h04;
  localparam logic [5:0] G_CHECK_COUNT = 6'h08;
  localparam logic [5:0] G_ERR_COUNT   = 6'h0C;
  localparam logic [5:0] G_CYCLE_COUNT = 6'h10;
  localparam logic [5:0] G_LOG_POP     = 6'h14;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DONE   = 2'd1,
    FAILED = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    RUNNING = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } verdict_t;

endpackage

// File: rtl/test_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/test_monitor.sv
// Memory-mapped test-control peripheral: per-channel command windows, global counters,
// cycle watchdog, failure log and a sticky pass/fail verdict.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int LOG_DEPTH    = 8,
  parameter int MAX_CYCLES   = 2500,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           rd_data,
  output logic                  access_fault,
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic                  failed
);
  localparam int WIN_W = ADDR_WIDTH - 6;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CYC_W = $clog2(MAX_CYCLES + 1);

  ch_state_t            ch_state      [NUM_CHANNELS];
  ch_state_t            ch_state_next [NUM_CHANNELS];
  logic [31:0]          arg_a         [NUM_CHANNELS];
  logic [31:0]          arg_b         [NUM_CHANNELS];
  logic [31:0]          caller        [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0] fail_count, check_count, err_count, fail_count_next;
  logic [CYC_W-1:0]     cyc_count, cyc_count_next;
  verdict_t             verdict, verdict_next;
  logic                 overflow;

  logic [WIN_W-1:0] win_idx;
  logic [5:0]       offset;
  logic [CH_W-1:0]  chan_idx;
  logic             misaligned, is_ch, is_glb;
  logic             ch_wr_ok, cmd_wr, wr_arg_a, wr_arg_b, wr_caller;
  logic             check_inc, fail_inc, err_inc, log_push, log_pop;
  logic             log_full, log_empty;
  logic [31:0]      log_head, log_entry;
  logic             all_done, any_failed, all_stopped;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign win_idx    = addr[ADDR_WIDTH-1:6];
  assign offset     = addr[5:0];
  assign chan_idx   = CH_W'(win_idx);
  assign misaligned = addr[1:0] != 2'b00;
  assign is_ch      = win_idx < WIN_W'(NUM_CHANNELS);
  assign is_glb     = win_idx == WIN_W'(NUM_CHANNELS);

  assign ch_wr_ok  = wr_en && is_ch && !misaligned;
  assign cmd_wr    = ch_wr_ok && offset == OFF_CMD && wr_strobe == 4'hF;
  assign wr_arg_a  = ch_wr_ok && offset == OFF_ARG_A;
  assign wr_arg_b  = ch_wr_ok && offset == OFF_ARG_B;
  assign wr_caller = ch_wr_ok && offset == OFF_CALLER;
  assign log_pop   = rd_en && is_glb && !misaligned && offset == G_LOG_POP && !log_empty;
  assign log_entry = {8'(win_idx), caller[chan_idx][23:0]};
  assign busy      = 1'b0;

  always_comb begin
    access_fault = 1'b0;
    if (rd_en || wr_en) begin
      if (misaligned) begin
        access_fault = 1'b1;
      end else if (is_ch) begin
        case (offset)
          OFF_CMD:                          access_fault = wr_en && wr_strobe != 4'hF;
          OFF_ARG_A, OFF_ARG_B, OFF_CALLER: access_fault = 1'b0;
          OFF_CH_STATE:                     access_fault = wr_en;
          default:                          access_fault = 1'b1;
        endcase
      end else if (is_glb) begin
        access_fault = (offset > G_LOG_POP) || wr_en;
      end else begin
        access_fault = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en && !misaligned) begin
      if (is_ch) begin
        case (offset)
          OFF_ARG_A:    rd_data = arg_a[chan_idx];
          OFF_ARG_B:    rd_data = arg_b[chan_idx];
          OFF_CALLER:   rd_data = caller[chan_idx];
          OFF_CH_STATE: rd_data = {30'd0, ch_state[chan_idx]};
          default:      rd_data = '0;
        endcase
      end else if (is_glb) begin
        case (offset)
          G_STATUS:      rd_data = {28'd0, overflow, log_empty, verdict};
          G_FAIL_COUNT:  rd_data = 32'(fail_count);
          G_CHECK_COUNT: rd_data = 32'(check_count);
          G_ERR_COUNT:   rd_data = 32'(err_count);
          G_CYCLE_COUNT: rd_data = 32'(cyc_count);
          G_LOG_POP:     rd_data = log_empty ? 32'd0 : log_head;
          default:       rd_data = '0;
        endcase
      end
    end
  end

  // Command decode; a channel that has left RUN only accumulates errors.
  always_comb begin
    check_inc = 1'b0;
    fail_inc  = 1'b0;
    err_inc   = 1'b0;
    log_push  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) ch_state_next[i] = ch_state[i];
    if (cmd_wr) begin
      if (ch_state[chan_idx] != RUN) begin
        err_inc = 1'b1;
      end else begin
        case (wr_data)
          CMD_CHECK_EQ: begin
            check_inc = 1'b1;
            if (arg_a[chan_idx] != arg_b[chan_idx]) begin
              fail_inc = 1'b1;
              log_push = 1'b1;
            end
          end
          CMD_CHECK_ALL_FAIL: begin
            fail_inc = 1'b1;
            log_push = 1'b1;
          end
          DONE_CODE: ch_state_next[chan_idx] = DONE;
          FAIL_CODE: begin
            ch_state_next[chan_idx] = FAILED;
            fail_inc = 1'b1;
          end
          default: err_inc = 1'b1;
        endcase
      end
    end
  end

  // Verdict looks at next-cycle channel state so it lands on the edge of the deciding write.
  always_comb begin
    all_done    = 1'b1;
    any_failed  = 1'b0;
    all_stopped = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_state_next[i] != DONE)   all_done    = 1'b0;
      if (ch_state_next[i] == FAILED) any_failed  = 1'b1;
      if (ch_state_next[i] == RUN)    all_stopped = 1'b0;
    end
    fail_count_next = sat_inc(fail_count, fail_inc);
    cyc_count_next  = (verdict == RUNNING && cyc_count != '1) ? cyc_count + CYC_W'(1) : cyc_count;
    verdict_next    = verdict;
    if (verdict == RUNNING) begin
      if (any_failed || (all_stopped && fail_count_next != '0))
        verdict_next = FAIL;
      else if (all_done && fail_count_next == '0)
        verdict_next = PASS;
      else if (cyc_count_next == CYC_W'(MAX_CYCLES))
        verdict_next = TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ch_state[i] <= RUN;
        arg_a[i]    <= '0;
        arg_b[i]    <= '0;
        caller[i]   <= '0;
      end
      fail_count  <= '0;
      check_count <= '0;
      err_count   <= '0;
      cyc_count   <= '0;
      verdict     <= RUNNING;
      overflow    <= 1'b0;
      done        <= 1'b0;
      passed      <= 1'b0;
      failed      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) ch_state[i] <= ch_state_next[i];
      for (int b = 0; b < 4; b++) begin
        if (wr_strobe[b]) begin
          if (wr_arg_a)  arg_a[chan_idx][8*b +: 8]  <= wr_data[8*b +: 8];
          if (wr_arg_b)  arg_b[chan_idx][8*b +: 8]  <= wr_data[8*b +: 8];
          if (wr_caller) caller[chan_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      fail_count  <= fail_count_next;
      check_count <= sat_inc(check_count, check_inc);
      err_count   <= sat_inc(err_count, err_inc);
      cyc_count   <= cyc_count_next;
      verdict     <= verdict_next;
      if (log_push && log_full && !log_pop) overflow <= 1'b1;
      done   <= verdict != RUNNING;
      passed <= verdict == PASS;
      failed <= verdict == FAIL || verdict == TIMEOUT;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk       (clk),
    .rst       (rst),
    .push      (log_push),
    .push_data (log_entry),
    .pop       (log_pop),
    .pop_data  (log_head),
    .full      (log_full),
    .empty     (log_empty)
  );

endmodule

// File: doc/test_monitor.md
Name: test_monitor

Overview:
Memory-mapped simulation/test-control peripheral on the core's AXI-space DBus port. It replaces probe-based sim calls (FENCE + mscratch) with synthesizable command registers, so directed software tests report results the same way in RTL sim and on FPGA. It supports NUM_CHANNELS independent command windows, one per hart or test thread, a global cycle watchdog and a failure-log FIFO. The overall verdict is exposed on status pins.

Parameters:
- ADDR_WIDTH, 8: byte address width of the monitor window.
- NUM_CHANNELS, 2: command windows, 64 B each, at channel*0x40.
- LOG_DEPTH, 8: failure-log FIFO entries; power of 2.
- MAX_CYCLES, 2500: watchdog limit in clk cycles.
- CNT_WIDTH, 16: width of the fail, check and error counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rd_en  in  1  DBus read strobe
- wr_en  in  1  DBus write strobe
- addr  in  ADDR_WIDTH  byte address, word-aligned
- wr_data  in  32  write data
- wr_strobe  in  4  byte enables
- rd_data  out  32  read data, combinational, same cycle as rd_en
- access_fault  out  1  bad address or illegal write, combinational
- busy  out  1  tied 0
- done  out  1  sticky: verdict reached
- passed  out  1  sticky: done with zero failures
- failed  out  1  sticky: any failure, FAIL_CODE or timeout

Behaviour:
- Per-channel registers (offset within window):
  - 0x00 CMD (WO)
  - 0x04 ARG_A
  - 0x08 ARG_B
  - 0x0C CALLER
  - 0x10 CH_STATE (RO)
- Global block at NUM_CHANNELS*0x40:
  - +0x00 STATUS (RO): {overflow, log_empty, verdict[1:0]}
  - +0x04 FAIL_COUNT
  - +0x08 CHECK_COUNT
  - +0x0C ERR_COUNT
  - +0x10 CYCLE_COUNT
  - +0x14 LOG_POP (RO, pops): {chan[7:0], caller[23:0]}
- All counters and registers reset to 0. Outputs reset to done=0, passed=0, failed=0, busy=0. CH_STATE resets to RUN.
- ARG_A, ARG_B and CALLER honour wr_strobe per byte.
- A CMD write requires wr_strobe=4'hF; otherwise access_fault=1 and the write is ignored. The command executes on the clock edge of the write.
- CMD codes:
  - 0 CHECK_EQ: CHECK_COUNT++. If ARG_A != ARG_B, then FAIL_COUNT++ and {chan, CALLER[23:0]} is pushed to the log.
  - 1 CHECK_ALL_FAIL: FAIL_COUNT++, log push.
  - 0x0D15EA5E DONE: channel state becomes DONE.
  - 0xDEADBEEF FAIL: channel state becomes FAILED, FAIL_COUNT++.
  - Any other code: ERR_COUNT++, no state change.
- Channel FSM: RUN -> DONE | FAILED. DONE and FAILED are absorbing until rst. Commands in a non-RUN channel increment ERR_COUNT only.
- Global verdict FSM: RUNNING(0) -> PASS(1) | FAIL(2) | TIMEOUT(3). Absorbing.
  - PASS when all channels are DONE and FAIL_COUNT==0.
  - FAIL when any channel is FAILED, or all channels are non-RUN with FAIL_COUNT>0.
  - TIMEOUT when CYCLE_COUNT reaches MAX_CYCLES while RUNNING.
  - done/passed/failed are registered; they assert the cycle after the verdict transition.
- CYCLE_COUNT increments every cycle while RUNNING and freezes afterwards.
- Counters saturate at all-ones.
- Log FIFO:
  - Push when full: entry dropped, overflow sticky set; FAIL_COUNT still increments.
  - LOG_POP read when empty: returns 0, no pop.
  - Push and pop in the same cycle when full: both succeed.
- access_fault=1 for: an address beyond the global block; a write to any RO register; a misaligned address (addr[1:0]!=0).
- Writes after the verdict are still accepted (registers update) but cannot change the verdict.
- rst mid-run clears everything, including sticky outputs, next cycle.

Decomposition:
- Package test_monitor_pkg:
  - CMD_CHECK_EQ, CMD_CHECK_ALL_FAIL, DONE_CODE, FAIL_CODE
  - register offset constants
  - ch_state_t enum {RUN, DONE, FAILED}
  - verdict_t enum {RUNNING, PASS, FAIL, TIMEOUT}
- One sub-module, sync_fifo, parametrised by WIDTH and DEPTH; provides full, empty and same-cycle push/pop.

Test Plan:
- CH0 writes ARG_A=5, ARG_B=5, CMD=0; then CH0 and CH1 write DONE_CODE -> CHECK_COUNT=1, FAIL_COUNT=0, passed=1 and done=1 one cycle after the second DONE write.
- CH1 CALLER=0x123, ARG_A=1, ARG_B=2, CMD=0, then DONE on both channels -> FAIL_COUNT=1, failed=1; LOG_POP=0x01000123; a second LOG_POP returns 0 with log_empty=1.
- 9 failing checks with LOG_DEPTH=8 -> FAIL_COUNT=9, overflow=1; 8 pops return entries in push order.
- No commands issued -> verdict TIMEOUT at cycle 2500, CYCLE_COUNT=2500 frozen, failed=1.
- CMD write with wr_strobe=4'h3 -> access_fault=1, CH_STATE unchanged. CMD=0x42 -> ERR_COUNT=1. Write to FAIL_COUNT -> access_fault=1.
- CH0 writes FAIL_CODE, then rst at the next cycle -> verdict RUNNING, all counters 0, done=0 and failed=0 one cycle later.
